// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: assembles streamed weight words and biases into per-row
// write strobes for every neuron of every layer, then flags the network loaded.
module weight_load_ctrl #(
  parameter int unsigned layers               = 2,
  parameter int unsigned datawidth            = 11,
  parameter int unsigned rows [0:layers-1]    = '{30, 10},
  parameter int unsigned cols [0:layers-1]    = '{64, 30},
  parameter int unsigned max_rows             = 30,
  parameter int unsigned max_cols             = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_overall,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  s_valid,
  input  logic signed [2*datawidth-1:0]         s_data,
  output logic                                  s_ready,
  output logic                                  train,
  output logic [$clog2(layers)-1:0]             train_layer_select,
  output logic [$clog2(max_rows)-1:0]           row_sel,
  output logic [max_cols*datawidth-1:0]         weight_update,
  output logic [max_rows*2*datawidth-1:0]       bias_updates,
  output logic                                  busy,
  output logic                                  load_done,
  output logic                                  weights_valid
);

  localparam int unsigned LW   = $clog2(layers);
  localparam int unsigned RW   = $clog2(max_rows);
  localparam int unsigned CW   = $clog2(max_cols + 1);
  localparam int unsigned WW   = max_cols * datawidth;
  localparam int unsigned BW   = max_rows * 2 * datawidth;
  localparam int unsigned WSHW = $clog2(WW);
  localparam int unsigned BSHW = $clog2(BW);

  localparam logic [WW-1:0] WMASK = WW'({datawidth{1'b1}});
  localparam logic [BW-1:0] BMASK = BW'({(2*datawidth){1'b1}});

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    WRITE,
    NEXT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   layer_cnt;
  logic [RW-1:0]   row_cnt;
  logic [CW-1:0]   col_cnt;

  int unsigned     cols_l;
  int unsigned     rows_l;
  logic [WSHW-1:0] w_sh;
  logic [BSHW-1:0] b_sh;
  logic            load_start;
  logic            accept_w;
  logic            accept_b;
  logic            row_adv;
  logic            layer_adv;
  logic            done_set;
  logic            abort_now;

  // State register
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) state <= IDLE;
    else             state <= state_next;
  end

  // Next-state decode and datapath strobes; abort overrides every transition
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    accept_w   = 1'b0;
    accept_b   = 1'b0;
    row_adv    = 1'b0;
    layer_adv  = 1'b0;
    done_set   = 1'b0;
    abort_now  = 1'b0;
    cols_l     = cols[layer_cnt];
    rows_l     = rows[layer_cnt];
    w_sh       = WSHW'((cols_l - 32'(col_cnt) - 1) * datawidth);
    b_sh       = BSHW'((rows_l - 32'(row_cnt) - 1) * 2 * datawidth);
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = LOAD_W;
        end
      end
      LOAD_W: begin
        if (s_valid) begin
          accept_w = 1'b1;
          if (32'(col_cnt) == cols_l - 1) state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (s_valid) begin
          accept_b   = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: state_next = NEXT;
      NEXT: begin
        if (32'(row_cnt) < rows_l - 1) begin
          row_adv    = 1'b1;
          state_next = LOAD_W;
        end else if (32'(layer_cnt) < layers - 1) begin
          layer_adv  = 1'b1;
          state_next = LOAD_W;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_set   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      abort_now  = 1'b1;
      state_next = IDLE;
      accept_w   = 1'b0;
      accept_b   = 1'b0;
      row_adv    = 1'b0;
      layer_adv  = 1'b0;
      done_set   = 1'b0;
    end
  end

  // Control outputs registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      train     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      s_ready   <= (state_next == LOAD_W) || (state_next == LOAD_B);
      busy      <= (state_next != IDLE);
      train     <= (state_next == WRITE);
      load_done <= (state_next == DONE);
    end
  end

  // Counters and row/bias assembly registers
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      layer_cnt          <= '0;
      row_cnt            <= '0;
      col_cnt            <= '0;
      weight_update      <= '0;
      bias_updates       <= '0;
      train_layer_select <= '0;
      row_sel            <= '0;
      weights_valid      <= 1'b0;
    end else begin
      if (load_start) begin
        layer_cnt     <= '0;
        row_cnt       <= '0;
        col_cnt       <= '0;
        weight_update <= '0;
        bias_updates  <= '0;
        weights_valid <= 1'b0;
      end else if (accept_w) begin
        weight_update <= (weight_update & ~(WMASK << w_sh)) |
                         (WW'(s_data[datawidth-1:0]) << w_sh);
        col_cnt       <= col_cnt + CW'(1);
      end else if (accept_b) begin
        bias_updates       <= (bias_updates & ~(BMASK << b_sh)) |
                              (BW'($unsigned(s_data)) << b_sh);
        train_layer_select <= layer_cnt;
        row_sel            <= row_cnt;
      end else if (row_adv) begin
        row_cnt <= row_cnt + RW'(1);
        col_cnt <= '0;
      end else if (layer_adv) begin
        layer_cnt     <= layer_cnt + LW'(1);
        row_cnt       <= '0;
        col_cnt       <= '0;
        weight_update <= '0;
        bias_updates  <= '0;
      end
      if (done_set)  weights_valid <= 1'b1;
      if (abort_now) weights_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: checks weight_load_ctrl against a row/bias write model.
module tb_weight_load_ctrl;

  localparam int unsigned DW      = 11;
  localparam int unsigned WW      = 3 * DW;
  localparam int unsigned BW      = 2 * 2 * DW;
  localparam int unsigned N_BEATS = 11;
  localparam int unsigned TB_ROWS [0:1] = '{2, 1};
  localparam int unsigned TB_COLS [0:1] = '{3, 2};

  logic                  clk = 1'b0;
  logic                  rst_overall;
  logic                  start;
  logic                  abort;
  logic                  s_valid;
  logic signed [2*DW-1:0] s_data;
  logic                  s_ready;
  logic                  train;
  logic [0:0]            train_layer_select;
  logic [0:0]            row_sel;
  logic [WW-1:0]         weight_update;
  logic [BW-1:0]         bias_updates;
  logic                  busy;
  logic                  load_done;
  logic                  weights_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_start;

  logic [2*DW-1:0] beats [0:N_BEATS-1];

  int            tr_l [$];
  int            tr_r [$];
  logic [WW-1:0] tr_wu [$];
  logic [BW-1:0] tr_bu [$];
  int            tr_cyc [$];
  int            ld_cyc [$];

  int            exp_l [$];
  int            exp_r [$];
  logic [WW-1:0] exp_wu [$];
  logic [BW-1:0] exp_bu [$];

  weight_load_ctrl #(
    .layers   (2),
    .datawidth(DW),
    .rows     (TB_ROWS),
    .cols     (TB_COLS),
    .max_rows (2),
    .max_cols (3)
  ) dut (
    .clk               (clk),
    .rst_overall       (rst_overall),
    .start             (start),
    .abort             (abort),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .train             (train),
    .train_layer_select(train_layer_select),
    .row_sel           (row_sel),
    .weight_update     (weight_update),
    .bias_updates      (bias_updates),
    .busy              (busy),
    .load_done         (load_done),
    .weights_valid     (weights_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every row write and completion pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (train) begin
      tr_l.push_back(int'(train_layer_select));
      tr_r.push_back(int'(row_sel));
      tr_wu.push_back(weight_update);
      tr_bu.push_back(bias_updates);
      tr_cyc.push_back(cyc);
    end
    if (load_done) ld_cyc.push_back(cyc);
  end

  task automatic clear_obs();
    tr_l.delete(); tr_r.delete(); tr_wu.delete(); tr_bu.delete();
    tr_cyc.delete(); ld_cyc.delete();
  endtask

  // Reference: walk the stream layer by layer, row by row; a row's first
  // weight lands in the top slot, biases accumulate top-down within a layer.
  function automatic void build_expected();
    int idx;
    logic [63:0] w;
    logic [63:0] bacc;
    exp_l.delete(); exp_r.delete(); exp_wu.delete(); exp_bu.delete();
    idx = 0;
    for (int l = 0; l < 2; l++) begin
      bacc = '0;
      for (int r = 0; r < int'(TB_ROWS[l]); r++) begin
        w = '0;
        for (int c = 0; c < int'(TB_COLS[l]); c++) begin
          w = w | (64'(beats[idx][DW-1:0]) << ((int'(TB_COLS[l]) - 1 - c) * int'(DW)));
          idx++;
        end
        bacc = bacc | (64'(beats[idx]) << ((int'(TB_ROWS[l]) - 1 - r) * 2 * int'(DW)));
        idx++;
        exp_l.push_back(l);
        exp_r.push_back(r);
        exp_wu.push_back(w[WW-1:0]);
        exp_bu.push_back(bacc[BW-1:0]);
      end
    end
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < int'(N_BEATS); i++) beats[i] = (2*DW)'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(N_BEATS); i++) beats[i] = (2*DW)'($urandom);
  endtask

  // Stream driver. mode 0: back-to-back, 1: valid on even cycles, 2: random gaps.
  // Returns at the load_done cycle, after an abort, or when the budget expires.
  task automatic drive_load(input bit do_start, input int mode, input int abort_after,
                            input bit hold_start);
    int idx;
    bit acc;
    idx = 0;
    acc = 1'b0;
    if (do_start) begin
      @(posedge clk);
      clear_obs();
      @(negedge clk);
      start   = 1'b1;
      s_valid = 1'b0;
      t_start = cyc;
    end
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (acc) idx++;
      acc = 1'b0;
      if (load_done) break;
      if (abort_after >= 0 && idx == abort_after) begin
        s_valid = 1'b0;
        abort   = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        break;
      end
      if (idx < int'(N_BEATS)) begin
        case (mode)
          0:       s_valid = 1'b1;
          1:       s_valid = (k % 2 == 0);
          default: s_valid = ($urandom_range(0, 3) != 0);
        endcase
        s_data = beats[idx];
      end else begin
        s_valid = 1'b0;
      end
      acc = s_valid && s_ready;
    end
  endtask

  task automatic test_reset();
    rst_overall = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_ready, train, busy, load_done, weights_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 00000", {s_ready, train, busy, load_done, weights_valid});
    end
    n_cmp++;
    if ({train_layer_select, row_sel} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_sel: got %b, expected 00", {train_layer_select, row_sel});
    end
    rst_overall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (weight_update !== '0 || bias_updates !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got w=%h b=%h, expected 0", weight_update, bias_updates);
    end
    n_cmp++;
    if ({s_ready, busy, weights_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, expected 000", {s_ready, busy, weights_valid});
    end
  endtask

  task automatic test_full_load(output int len);
    logic [WW-1:0] w0;
    logic [BW-1:0] b0;
    logic [WW-1:0] w2;
    int last_tr;
    fill_seq();
    build_expected();
    drive_load(1'b1, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    len = (ld_cyc.size() > 0) ? ld_cyc[0] - t_start : -1;
    n_cmp++;
    if (tr_l.size() != exp_l.size()) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, expected %0d", tr_l.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
      n_cmp++;
      if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
        n_fail++;
        $display("FAIL full_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                 i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
      end
    end
    w0 = (tr_wu.size() > 0) ? tr_wu[0] : 'x;
    b0 = (tr_bu.size() > 0) ? tr_bu[0] : 'x;
    w2 = (tr_wu.size() > 2) ? tr_wu[2] : 'x;
    n_cmp++;
    if (w0 !== {11'd1, 11'd2, 11'd3} || b0 !== {22'd4, 22'd0}) begin
      n_fail++;
      $display("FAIL first_row: got w=%h b=%h, expected w=%h b=%h", w0, b0,
               {11'd1, 11'd2, 11'd3}, {22'd4, 22'd0});
    end
    n_cmp++;
    if (w2[32:22] !== 11'd0) begin
      n_fail++;
      $display("FAIL third_row_upper: got %h, expected 0", w2[32:22]);
    end
    last_tr = (tr_cyc.size() > 0) ? tr_cyc[tr_cyc.size()-1] : -100;
    n_cmp++;
    if (ld_cyc.size() != 1 || ld_cyc[0] != last_tr + 2) begin
      n_fail++;
      $display("FAIL load_done_timing: got %0d pulses first at %0d, expected 1 at %0d",
               ld_cyc.size(), (ld_cyc.size() > 0) ? ld_cyc[0] : -1, last_tr + 2);
    end
    n_cmp++;
    if (weights_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end_flags: got valid=%b busy=%b, expected 1 0", weights_valid, busy);
    end
  endtask

  task automatic test_valid_toggle(input int ref_len);
    int len;
    fill_seq();
    build_expected();
    drive_load(1'b1, 1, -1, 1'b0);
    repeat (2) @(negedge clk);
    len = (ld_cyc.size() > 0) ? ld_cyc[0] - t_start : -1;
    n_cmp++;
    if (tr_l.size() != exp_l.size()) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d writes, expected %0d", tr_l.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
      n_cmp++;
      if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
        n_fail++;
        $display("FAIL toggle_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                 i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
      end
    end
    n_cmp++;
    if (len != ref_len + 11) begin
      n_fail++;
      $display("FAIL toggle_length: got %0d cycles, expected %0d", len, ref_len + 11);
    end
    n_cmp++;
    if (weights_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_valid: got %b, expected 1", weights_valid);
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 3; it++) begin
      fill_rand();
      build_expected();
      drive_load(1'b1, 2, -1, 1'b0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tr_l.size() != exp_l.size() || ld_cyc.size() != 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d writes %0d done, expected %0d writes 1 done",
                 it, tr_l.size(), ld_cyc.size(), exp_l.size());
      end
      for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
        n_cmp++;
        if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                   it, i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int ready_seen;
    fill_rand();
    build_expected();
    drive_load(1'b1, 0, 5, 1'b0);
    n_cmp++;
    if ({s_ready, busy, weights_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL abort_flags: got ready/busy/valid=%b, expected 000", {s_ready, busy, weights_valid});
    end
    ready_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = (2*DW)'($urandom);
      if (s_ready) ready_seen++;
    end
    s_valid = 1'b0;
    n_cmp++;
    if (tr_l.size() != 1 || ld_cyc.size() != 0 || ready_seen != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d writes %0d done %0d ready, expected 1 0 0",
               tr_l.size(), ld_cyc.size(), ready_seen);
    end
    n_cmp++;
    if (tr_l.size() < 1 || tr_wu[0] !== exp_wu[0] || tr_bu[0] !== exp_bu[0]) begin
      n_fail++;
      $display("FAIL abort_row0: got %0d writes, expected row0 w=%h b=%h", tr_l.size(), exp_wu[0], exp_bu[0]);
    end
    fill_rand();
    build_expected();
    drive_load(1'b1, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (tr_l.size() != exp_l.size() || weights_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_count: got %0d writes valid=%b, expected %0d writes valid=1",
               tr_l.size(), weights_valid, exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
      n_cmp++;
      if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
        n_fail++;
        $display("FAIL reload_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                 i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    fill_rand();
    build_expected();
    drive_load(1'b1, 0, -1, 1'b1);
    n_cmp++;
    if (tr_l.size() != exp_l.size() || load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d writes done=%b, expected %0d done=1",
               tr_l.size(), load_done, exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
      n_cmp++;
      if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
        n_fail++;
        $display("FAIL busy_start_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                 i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || weights_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_idle: got busy=%b valid=%b, expected 0 1", busy, weights_valid);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_reload: got busy=%b ready=%b, expected 1 1", busy, s_ready);
    end
    #2;
    clear_obs();
    fill_rand();
    build_expected();
    drive_load(1'b0, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (tr_l.size() != exp_l.size() || weights_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL second_load_count: got %0d writes valid=%b, expected %0d valid=1",
               tr_l.size(), weights_valid, exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < tr_l.size(); i++) begin
      n_cmp++;
      if (tr_l[i] != exp_l[i] || tr_r[i] != exp_r[i] || tr_wu[i] !== exp_wu[i] || tr_bu[i] !== exp_bu[i]) begin
        n_fail++;
        $display("FAIL second_load_write%0d: got L%0d r%0d w=%h b=%h, expected L%0d r%0d w=%h b=%h",
                 i, tr_l[i], tr_r[i], tr_wu[i], tr_bu[i], exp_l[i], exp_r[i], exp_wu[i], exp_bu[i]);
      end
    end
  endtask

  task automatic test_reset_in_write();
    bit seen;
    int train_after;
    int busy_after;
    seen = 1'b0;
    @(posedge clk);
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = (2*DW)'($urandom);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (train) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_write_reach: got no train within 50 cycles, expected one");
    end
    #1 rst_overall = 1'b1;
    #1;
    n_cmp++;
    if ({s_ready, train, busy, load_done, weights_valid, train_layer_select, row_sel} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_async_ctrl: got %b, expected 0000000",
               {s_ready, train, busy, load_done, weights_valid, train_layer_select, row_sel});
    end
    n_cmp++;
    if (weight_update !== '0 || bias_updates !== '0) begin
      n_fail++;
      $display("FAIL rst_async_data: got w=%h b=%h, expected 0", weight_update, bias_updates);
    end
    @(negedge clk);
    rst_overall = 1'b0;
    train_after = 0;
    busy_after  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (train) train_after++;
      if (busy) busy_after++;
    end
    s_valid = 1'b0;
    n_cmp++;
    if (train_after != 0 || busy_after != 0) begin
      n_fail++;
      $display("FAIL rst_no_retrain: got %0d train %0d busy cycles, expected 0 0", train_after, busy_after);
    end
  endtask

  initial begin
    int b2b_len;
    rst_overall = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    t_start     = 0;
    test_reset();
    test_full_load(b2b_len);
    test_valid_toggle(b2b_len);
    test_random_gaps();
    test_abort();
    test_start_while_busy();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
